hififo_fpc_scheduler: RTL
=========================

// Module: hififo_fpc_scheduler
// PURPOSE
//  Shares the PCIe read-request (TX) path between NCH from-PC FIFO channels.
//  Each channel is host-programmed with a 512-byte-aligned buffer address and a block count.
//  The block grants pending channels round-robin and issues one 512-byte read request per grant (tag + address).
//  It returns rr_ready to the winning FIFO and marks the final block's tag so the completion raises the interrupt.
// PARAMETERS
//  NCH    4   number of from-PC FIFO channels (1..4; channel id fills tag[5:4], tag[6]=0)
//  CBITS  20  width of per-channel remaining-block counter
// PORTS
//  clock         in   1        single clock for all logic
//  reset_n       in   1        asynchronous, active-low reset
//  cfg_valid     in   1        program one channel (single-cycle strobe)
//  cfg_channel   in   2        channel being programmed
//  cfg_addr      in   64       start byte address; bits [8:0] ignored (forced 0)
//  cfg_blocks    in   CBITS    number of 512-byte blocks to fetch
//  cfg_rejected  out  1        1-cycle pulse: cfg_valid hit a busy channel or an out-of-range channel
//  busy          out  NCH      channel has remaining blocks > 0
//  ch_rr_valid   in   NCH      per-channel request-wanted (FIFO rr_valid)
//  ch_tag_low    in   3*NCH    per-channel tag_low, channel i at [3i+2:3i]
//  ch_rr_ready   out  NCH      1-cycle one-hot pulse: request for that channel was sent
//  tx_valid      out  1        read request valid to TX engine
//  tx_ready      in   1        TX engine accepts request
//  tx_tag        out  8        {last, 1'b0, channel[1:0], 1'b0, tag_low[2:0]}
//  tx_addr       out  64       request byte address, [8:0]=0; length is fixed at 128 DW
// BEHAVIOUR
//  Reset (async, reset_n=0)
//   - All state clears: every channel idle, remaining=0, address=0, RR pointer=0, FSM=ARB.
//   - Outputs: tx_valid=0, ch_rr_ready=0, busy=0, cfg_rejected=0, tx_tag=0, tx_addr=0.
//   - Reset mid-handshake drops tx_valid immediately; the request is lost by design.
//  Config (registered, takes effect next cycle)
//   - Accepted when remaining[cfg_channel]==0: addr<=cfg_addr&~0x1FF, remaining<=cfg_blocks.
//   - cfg_blocks==0 is accepted and leaves the channel idle.
//   - A busy channel or cfg_channel>=NCH is not modified; cfg_rejected pulses the next cycle.
//  Eligibility: elig[i] = ch_rr_valid[i] && remaining[i]!=0.
//  FSM, one request in flight:
//   ARB
//    - If any elig, grant the first eligible at or after RR pointer (circular).
//    - Latch g, tx_tag and tx_addr=addr[g]; last = (remaining[g]==1).
//    - Go to ISSUE. If nothing is eligible, stay in ARB.
//   ISSUE
//    - tx_valid=1 with tx_tag/tx_addr held stable until tx_ready.
//    - On the tx_valid&&tx_ready cycle:
//      - addr[g]+=512 (64-bit wrap);
//      - remaining[g]-=1;
//      - RR pointer <= g+1 mod NCH;
//      - go to ACK.
//   ACK
//    - ch_rr_ready[g]=1 for exactly this cycle, tx_valid=0, then go to ARB.
//  Timing
//   - Grant-to-tx_valid latency is 1 cycle. Handshake at cycle H gives rr_ready at H+1.
//   - The earliest next grant is at H+2, so the FIFO's rr_holdoff is visible before re-arbitration.
//  Boundary conditions
//   - ch_rr_valid dropping during ISSUE does not withdraw the request.
//   - A cfg to channel g while it is in flight is rejected, since remaining>0.
//   - After the last block, busy[g] drops on the handshake+1 edge; a new cfg is accepted from then.
//   - At most 1 request per 3 cycles (ARB, ISSUE, ACK); back-to-back tx_ready is never seen.
// TESTING
//  - Reset: hold reset_n=0 with ch_rr_valid=4'hF -> tx_valid=0, busy=0, ch_rr_ready=0 throughout.
//  - Single channel: cfg ch1, addr=0x1000_0123, blocks=3; rr_valid[1]=1, tag_low 0,1,2; tx_ready=1 ->
//    addrs 0x1000_0000/0200/0400; tags 0x10, 0x11, 0x92; busy[1] falls after the 3rd request.
//  - Round-robin: ch0..3 programmed with 2 blocks each, all rr_valid, tx_ready=1 ->
//    grant order 0,1,2,3,0,1,2,3; each ch_rr_ready pulse is 1 cycle, one-hot, and spaced 3 cycles apart.
//  - Backpressure: tx_ready=0 for 10 cycles in ISSUE -> tx_tag/tx_addr stable, no rr_ready;
//    rr_ready follows 1 cycle after tx_ready.
//  - Rejection: cfg ch2 while busy, or cfg_channel=3 with NCH=3 -> cfg_rejected pulses once, state unchanged.
//  - Wrap/reset: addr=0xFFFF_FFFF_FFFF_FE00, blocks=2 -> 2nd addr=0;
//    assert reset_n=0 in ISSUE -> tx_valid drops asynchronously, busy=0.

Source files
------------

// File: rtl/hififo_fpc_scheduler.sv
// hififo_fpc_scheduler
// Round-robin scheduler that shares one PCIe read-request (TX) path between
// NCH from-PC FIFO channels. Each channel holds a 512-byte-aligned address and
// a count of remaining 512-byte blocks. Only one request is in flight at a time.
// Each request walks ARB -> ISSUE -> ACK, so the FIFO's rr_ready pulse is seen
// before the next arbitration.

module hififo_fpc_scheduler #(
  parameter int NCH   = 4,
  parameter int CBITS = 20
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               cfg_valid_i,
  input  logic [1:0]         cfg_channel_i,
  input  logic [63:0]        cfg_addr_i,
  input  logic [CBITS-1:0]   cfg_blocks_i,
  output logic               cfg_rejected_o,
  output logic [NCH-1:0]     busy_o,
  input  logic [NCH-1:0]     ch_rr_valid_i,
  input  logic [3*NCH-1:0]   ch_tag_low_i,
  output logic [NCH-1:0]     ch_rr_ready_o,
  output logic               tx_valid_o,
  input  logic               tx_ready_i,
  output logic [7:0]         tx_tag_o,
  output logic [63:0]        tx_addr_o
);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CBITS-1:0] remaining_q [NCH];
  logic [CBITS-1:0] remaining_d [NCH];
  logic [63:0]      addr_q      [NCH];
  logic [63:0]      addr_d      [NCH];
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       tag_q, tag_d;
  logic [63:0]      tx_addr_q, tx_addr_d;
  logic             cfg_rej_q, cfg_rej_d;

  logic [NCH-1:0]   elig;
  logic             handshake;
  logic             cfg_accept;
  logic             found;
  logic [1:0]       pick;
  logic [2:0]       pick_tag_low;

  // Per-channel status: busy while blocks remain, eligible when the FIFO also wants data.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign busy_o[gi]        = (remaining_q[gi] != '0);
    assign elig[gi]          = ch_rr_valid_i[gi] & busy_o[gi];
    assign ch_rr_ready_o[gi] = (state_q == ST_ACK) && (grant_q == 2'(gi));
  end

  assign tx_valid_o     = (state_q == ST_ISSUE);
  assign tx_tag_o       = tag_q;
  assign tx_addr_o      = tx_addr_q;
  assign cfg_rejected_o = cfg_rej_q;
  assign handshake      = (state_q == ST_ISSUE) && tx_ready_i;

  // A channel may only be reprogrammed once it has drained; out-of-range ids never match.
  always_comb begin
    cfg_accept = 1'b0;
    if (cfg_valid_i && (int'(cfg_channel_i) < NCH)) begin
      cfg_accept = (remaining_q[cfg_channel_i] == '0);
    end
  end

  // Circular search for the first eligible channel at or after the RR pointer.
  always_comb begin
    int cand;
    found = 1'b0;
    pick  = rr_ptr_q;
    cand  = 0;
    for (int k = 0; k < NCH; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NCH) begin
        cand = cand - NCH;
      end
      if (!found && elig[2'(cand)]) begin
        found = 1'b1;
        pick  = 2'(cand);
      end
    end
  end

  // Select the winning channel's tag_low field.
  always_comb begin
    pick_tag_low = '0;
    for (int i = 0; i < NCH; i++) begin
      if (pick == 2'(i)) begin
        pick_tag_low = ch_tag_low_i[3*i +: 3];
      end
    end
  end

  // Request FSM: latch grant/tag/address in ARB, hold in ISSUE, pulse rr_ready in ACK.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tag_d     = tag_q;
    tx_addr_d = tx_addr_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      ST_ARB: begin
        if (found) begin
          grant_d   = pick;
          tag_d     = {(remaining_q[pick] == CBITS'(1)), 1'b0, pick, 1'b0, pick_tag_low};
          tx_addr_d = addr_q[pick];
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (tx_ready_i) begin
          rr_ptr_d = ((int'(grant_q) + 1) >= NCH) ? 2'd0 : (grant_q + 2'd1);
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Channel bookkeeping: load on accepted config, advance one block per handshake.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      remaining_d[i] = remaining_q[i];
      addr_d[i]      = addr_q[i];
      if (cfg_accept && (cfg_channel_i == 2'(i))) begin
        remaining_d[i] = cfg_blocks_i;
        addr_d[i]      = {cfg_addr_i[63:9], 9'd0};
      end else if (handshake && (grant_q == 2'(i))) begin
        remaining_d[i] = remaining_q[i] - CBITS'(1);
        addr_d[i]      = addr_q[i] + 64'd512;
      end
    end
    cfg_rej_d = cfg_valid_i && !cfg_accept;
  end

  // State registers; reset abandons any request in flight.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_ARB;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      tag_q     <= '0;
      tx_addr_q <= '0;
      cfg_rej_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        remaining_q[i] <= '0;
        addr_q[i]      <= '0;
      end
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      tag_q     <= tag_d;
      tx_addr_q <= tx_addr_d;
      cfg_rej_q <= cfg_rej_d;
      for (int i = 0; i < NCH; i++) begin
        remaining_q[i] <= remaining_d[i];
        addr_q[i]      <= addr_d[i];
      end
    end
  end

endmodule
